// File: rtl/bnn_pkg.sv
// Shared types and image geometry for the binary conv front end (window scanner and extractor).
package bnn_pkg;
    localparam int IMG_DIM = 28;
    localparam int K       = 3;
    localparam int COORD_W = 5;

    typedef logic [COORD_W-1:0] coord_t;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_e;
    typedef logic [K-1:0][K-1:0] window_t;
endpackage

// File: rtl/window_extract.sv
// Combinational KxK window slice of the binary image at origin (row, col).
// WINDOW_SCANNER_PAD_EN: origin is the window centre and out-of-image taps read as 0.
module window_extract
    import bnn_pkg::*;
(
    input  logic [IMG_DIM-1:0][IMG_DIM-1:0] pixels,
    input  coord_t                          row,
    input  coord_t                          col,
    output window_t                         window
);
`ifdef WINDOW_SCANNER_PAD_EN
    localparam int P  = K / 2;
    localparam int IW = COORD_W + 2;
`endif

    for (genvar gi = 0; gi < K; gi++) begin : g_row
        for (genvar gj = 0; gj < K; gj++) begin : g_col
`ifdef WINDOW_SCANNER_PAD_EN
            // Unsigned arithmetic: a negative tap wraps far above IMG_DIM, so one compare covers both edges.
            logic [IW-1:0] pr;
            logic [IW-1:0] pc;
            assign pr = {2'b00, row} + IW'(gi) - IW'(P);
            assign pc = {2'b00, col} + IW'(gj) - IW'(P);
            assign window[gi][gj] = (pr < IW'(IMG_DIM)) && (pc < IW'(IMG_DIM))
                                    ? pixels[pr[COORD_W-1:0]][pc[COORD_W-1:0]] : 1'b0;
`else
            coord_t pr;
            coord_t pc;
            assign pr = row + coord_t'(gi);
            assign pc = col + coord_t'(gj);
            assign window[gi][gj] = pixels[pr][pc];
`endif
        end
    end
endmodule

// File: rtl/window_scanner.sv
// Raster-order KxK window scanner with valid/ready output, one window per accepted handshake.
// WINDOW_SCANNER_PAD_EN: zero-padded scan covering every pixel as an origin.
module window_scanner
    import bnn_pkg::*;
#(
    parameter int STRIDE = 1
)(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [IMG_DIM-1:0][IMG_DIM-1:0] pixels,
    output logic                            win_valid,
    input  logic                            win_ready,
    output window_t                         window,
    output coord_t                          win_row,
    output coord_t                          win_col,
    output logic                            win_last,
    output logic                            busy,
    output logic                            done
);
`ifdef WINDOW_SCANNER_PAD_EN
    localparam int ORIGIN_MAX = IMG_DIM - 1;
`else
    localparam int ORIGIN_MAX = IMG_DIM - K;
`endif
    localparam coord_t LAST_ORIGIN = coord_t'((ORIGIN_MAX / STRIDE) * STRIDE);
    localparam coord_t STEP        = coord_t'(STRIDE);

    scan_state_e state_reg, state_next;
    coord_t      row_reg, row_next;
    coord_t      col_reg, col_next;
    window_t     window_reg;
    window_t     ext_window;
    logic        last_reg;
    logic        handshake;
    logic        load_first;
    logic        advance;

    assign handshake  = (state_reg == SCAN) && win_ready;
    assign load_first = (state_reg == IDLE) && start;
    assign advance    = handshake && !last_reg;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (handshake && last_reg) state_next = DONE;
            DONE:    if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        win_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_reg)
            SCAN: begin
                win_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Next origin is computed combinationally so its window registers on the same edge as the handshake.
    always_comb begin
        row_next = row_reg;
        col_next = col_reg;
        if (load_first) begin
            row_next = '0;
            col_next = '0;
        end else if (advance) begin
            if (col_reg == LAST_ORIGIN) begin
                col_next = '0;
                row_next = row_reg + STEP;
            end else begin
                col_next = col_reg + STEP;
            end
        end
    end

    window_extract u_extract (
        .pixels (pixels),
        .row    (row_next),
        .col    (col_next),
        .window (ext_window)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            row_reg    <= '0;
            col_reg    <= '0;
            window_reg <= '0;
            last_reg   <= 1'b0;
        end else if (load_first || advance) begin
            row_reg    <= row_next;
            col_reg    <= col_next;
            window_reg <= ext_window;
            last_reg   <= (row_next == LAST_ORIGIN) && (col_next == LAST_ORIGIN);
        end
    end

    assign window   = window_reg;
    assign win_row  = row_reg;
    assign win_col  = col_reg;
    assign win_last = last_reg;
endmodule

// File: tb/tb_window_scanner.sv
// Randomized bench for window_scanner: index-based scan model plus a STRIDE=2 instance check.
`timescale 1ns/1ps
module tb_window_scanner;
`ifdef WINDOW_SCANNER_PAD_EN
    localparam int OFF = 1;
    localparam int N_AX = 28;
    localparam int N_AX2 = 14;
    localparam int LAST2 = 26;
    localparam int SINGLE_WIN = 'h010;
    localparam int FIRST_ONES = 'h1B0;
`else
    localparam int OFF = 0;
    localparam int N_AX = 26;
    localparam int N_AX2 = 13;
    localparam int LAST2 = 24;
    localparam int SINGLE_WIN = 'h001;
    localparam int FIRST_ONES = 'h1FF;
`endif
    localparam int N_WIN  = N_AX * N_AX;
    localparam int N_WIN2 = N_AX2 * N_AX2;

    logic clk = 1'b0;
    logic reset, start, win_ready;
    logic [27:0][27:0] pix;
    logic win_valid, win_last, busy, done;
    logic [2:0][2:0] window;
    logic [4:0] win_row, win_col;
    logic win_valid2, win_last2, busy2, done2;
    logic [2:0][2:0] window2;
    logic [4:0] win_row2, win_col2;

    int n_cmp = 0, n_fail = 0;
    int m_state = 0, m_idx = 0;     // 0 idle, 1 scanning, 2 done
    int rdy_mode = 0, stall_cnt = 0;
    int hs_cnt = 0, hs03 = 0, last_r = -1, last_c = -1;
    int idx2 = 0;
    bit done2_q = 0, chk_en = 0;

    always #5 clk = ~clk;

    window_scanner #(.STRIDE(1)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pixels(pix),
        .win_valid(win_valid), .win_ready(win_ready), .window(window),
        .win_row(win_row), .win_col(win_col), .win_last(win_last),
        .busy(busy), .done(done)
    );

    window_scanner #(.STRIDE(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .pixels(pix),
        .win_valid(win_valid2), .win_ready(1'b1), .window(window2),
        .win_row(win_row2), .win_col(win_col2), .win_last(win_last2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Window value straight from the pixel definition, with optional zero border.
    function automatic int exp_win(input int r, input int c);
        int w, rr, cc;
        w = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr = r + i - OFF;
                cc = c + j - OFF;
                if (rr >= 0 && rr < 28 && cc >= 0 && cc < 28 && pix[rr][cc])
                    w = w | (1 << (i * 3 + j));
            end
        end
        return w;
    endfunction

    // Scan model: index of the window currently on offer.
    always @(posedge clk) begin
        if (reset) begin
            m_state = 0;
            m_idx = 0;
        end else begin
            case (m_state)
                0: if (start) begin m_state = 1; m_idx = 0; end
                1: if (win_ready) begin
                    if (m_idx == N_WIN - 1) m_state = 2;
                    else m_idx++;
                end
                2: if (!start) m_state = 0;
                default: m_state = 0;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_state != 1) stall_cnt = 0;
        if (rdy_mode == 0) win_ready = 1'b1;
        else if (m_state == 1 && m_idx == 3 && stall_cnt < 5) begin
            win_ready = 1'b0;
            stall_cnt++;
        end else win_ready = ($urandom_range(0, 99) < 70);
    end

    always @(negedge clk) begin
        int er, ec;
        if (chk_en) begin
            chk("valid", win_valid, m_state == 1);
            chk("busy", busy, m_state == 1);
            chk("done", done, m_state == 2);
            if (m_state == 1) begin
                er = m_idx / N_AX;
                ec = m_idx % N_AX;
                chk("row", win_row, er);
                chk("col", win_col, ec);
                chk("last", win_last, m_idx == N_WIN - 1);
                chk("window", window, exp_win(er, ec));
                if (rdy_mode == 1 && m_idx == 3 && stall_cnt >= 1 && stall_cnt <= 5) begin
                    chk("stall_row", win_row, 0);
                    chk("stall_col", win_col, 3);
                end
            end
            if (win_valid && win_ready) begin
                hs_cnt++;
                if (win_row == 0 && win_col == 3) hs03++;
                if (win_last) begin last_r = win_row; last_c = win_col; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (done2 && !done2_q) chk("s2_count", idx2, N_WIN2);
            done2_q = done2;
            if (!busy2) idx2 = 0;
            if (win_valid2) begin
                chk("s2_row", win_row2, (idx2 / N_AX2) * 2);
                chk("s2_col", win_col2, (idx2 % N_AX2) * 2);
                chk("s2_last", win_last2, idx2 == N_WIN2 - 1);
                chk("s2_window", window2, exp_win((idx2 / N_AX2) * 2, (idx2 % N_AX2) * 2));
                if (win_last2) begin
                    chk("s2_last_row", win_row2, LAST2);
                    chk("s2_last_col", win_col2, LAST2);
                end
                idx2++;
            end
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("scan_finished", done, 1);
    endtask

    task automatic run_scan(input int mode, input int first_exp, input bit chk_first);
        rdy_mode = mode;
        hs_cnt = 0;
        hs03 = 0;
        start = 1'b1;
        @(negedge clk);
        chk("first_valid", win_valid, 1);
        chk("first_row", win_row, 0);
        chk("first_col", win_col, 0);
        if (chk_first) chk("first_window", window, first_exp);
        wait_done();
        chk("win_count", hs_cnt, N_WIN);
        chk("last_row", last_r, N_AX - 1);
        chk("last_col", last_c, N_AX - 1);
    endtask

    task automatic end_scan();
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_image();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                pix[r][c] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        win_ready = 1'b0;
        pix = '0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        chk("rst_valid", win_valid, 0);
        chk("rst_window", window, 0);
        chk("rst_row", win_row, 0);
        chk("rst_col", win_col, 0);
        chk("rst_last", win_last, 0);
        reset = 1'b0;
        @(negedge clk);

        $display("scan 1: all-ones image, ready high");
        pix = '1;
        run_scan(0, FIRST_ONES, 1);
        end_scan();

        $display("scan 2: single pixel at (0,0)");
        pix = '0;
        pix[0][0] = 1'b1;
        run_scan(0, SINGLE_WIN, 1);
        end_scan();

        $display("scan 3: random image, random ready, stall on (0,3)");
        rand_image();
        run_scan(1, 0, 0);
        chk("hs_0_3_once", hs03, 1);
        end_scan();

        $display("scan 4: reset at 100th window, then restart");
        rand_image();
        rdy_mode = 1;
        start = 1'b1;
        n = 0;
        while (!(m_state == 1 && m_idx == 99) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_100th", m_idx, 99);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", win_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_row", win_row, 0);
        chk("rst_mid_col", win_col, 0);
        hs_cnt = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("restart_valid", win_valid, 1);
        chk("restart_row", win_row, 0);
        chk("restart_col", win_col, 0);
        wait_done();
        chk("restart_count", hs_cnt, N_WIN);

        $display("scan 5: start held after done, then re-armed");
        repeat (50) @(negedge clk);
        chk("hold_done", done, 1);
        chk("hold_no_valid", win_valid, 0);
        start = 1'b0;
        @(negedge clk);
        chk("rearm_idle", done, 0);
        hs_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        chk("second_valid", win_valid, 1);
        wait_done();
        chk("second_count", hs_cnt, N_WIN);
        end_scan();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
